// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the score/lives display path: BCD digit width,
// the converter state encoding, the BCD digit type and a small constant
// helper used for elaboration-time range checks.
// -----------------------------------------------------------------------------
package display_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
    } b2b_state_t;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    // 10**n as a 64-bit constant; used to check that DIGITS decimal digits
    // can hold the largest BIN_W-bit value.
    function automatic longint pow10(input int n);
        longint acc;
        acc = 1;
        for (int i = 0; i < n; i++) begin
            acc = acc * 10;
        end
        return acc;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Combinational double-dabble correction for one BCD digit: digits of 5 or
// more get +3 so that the following left shift carries correctly into the
// next decimal digit. The largest result (9+3=12) still fits in 4 bits.
// Ports:
//   digit      in   DIGIT_W  scratch digit before the shift
//   corrected  out  DIGIT_W  digit after the conditional +3
// -----------------------------------------------------------------------------
module bcd_add3
    import display_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] corrected
);

    assign corrected = (digit >= DIGIT_W'(5)) ? digit + DIGIT_W'(3) : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential binary-to-BCD converter (shift-add-3 / double dabble). Converts
// the binary score/lives counters into packed BCD digits, one digit per HEX
// display. One bit is consumed per clock, so a conversion takes BIN_W+1
// cycles from the accepted start to the done pulse. The bcd result register
// is only written in the done cycle, so downstream displays never see the
// intermediate scratch digits.
// Ports:
//   clk    in   1         system clock, rising edge
//   reset  in   1         synchronous, active-high reset
//   start  in   1         conversion request, sampled only while idle
//   bin    in   BIN_W     binary value, captured when start is accepted
//   busy   out  1         high while a conversion is in progress
//   done   out  1         one-cycle pulse, bcd updated in the same cycle
//   bcd    out  4*DIGITS  packed BCD result, [3:0] = ones digit
// -----------------------------------------------------------------------------
module bin_to_bcd_seq
    import display_pkg::*;
#(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [BIN_W-1:0]           bin,
    output logic                       busy,
    output logic                       done,
    output logic [DIGIT_W*DIGITS-1:0]  bcd
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // The top digit never shifts out a 1 only if DIGITS decimal digits can
    // represent every BIN_W-bit value.
    generate
        if (!(pow10(DIGITS) > ((longint'(1) << BIN_W) - 1))) begin : g_param_check
            $error("bin_to_bcd_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
        end
    endgenerate

    b2b_state_t             state_reg;
    logic [BIN_W-1:0]       sr_reg;
    logic [BCD_W-1:0]       digits_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic [BCD_W-1:0]       bcd_reg;

    logic [BCD_W-1:0]       corrected;
    logic [BIN_W:0]         sr_rot;
    logic [BCD_W-1:0]       digits_next;
    logic [BIN_W-1:0]       sr_next;

    // Per-digit +3 correction, all digits in parallel.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .digit     (digits_reg[gi*DIGIT_W +: DIGIT_W]),
                .corrected (corrected[gi*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // {digits, sr} moves left by one. The bit leaving the top digit is
    // always 0 and wraps into the vacated sr LSB, where it is never used
    // as data (only sr's MSB is ever consumed).
    assign sr_rot      = {sr_reg, corrected[BCD_W-1]};
    assign sr_next     = sr_rot[BIN_W-1:0];
    assign digits_next = {corrected[BCD_W-2:0], sr_rot[BIN_W]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            sr_reg     <= '0;
            digits_reg <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            bcd_reg    <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sr_reg     <= bin;
                        digits_reg <= '0;
                        cnt_reg    <= CNT_W'(BIN_W);
                        busy_reg   <= 1'b1;
                        state_reg  <= SHIFT;
                    end
                end
                SHIFT: begin
                    digits_reg <= digits_next;
                    sr_reg     <= sr_next;
                    cnt_reg    <= cnt_reg - CNT_W'(1);
                    // Last bit shifted in: publish the result this edge.
                    if (cnt_reg == CNT_W'(1)) begin
                        bcd_reg   <= digits_next;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign bcd  = bcd_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Directed checks of bin_to_bcd_seq: reset state, latency and handshake,
// dropped start while busy, mid-conversion reset, back-to-back conversions,
// and a full sweep of all 10-bit inputs. Inputs change and outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [9:0]  bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;

    int n_vec;
    int n_err;

    bin_to_bcd_seq #(
        .BIN_W  (10),
        .DIGITS (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < 4; k++) begin
            r[k*4 +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Starts a conversion at the current falling edge (cycle 0) and returns
    // at the falling edge of the done cycle. Checks latency, busy during the
    // conversion, bcd stability until done, busy low in done cycle and result.
    task automatic run_conv(input logic [9:0] v, input logic [15:0] exp, input string tag);
        logic [15:0] prev;
        int lat;
        bit bad_busy;
        bit bad_hold;
        prev     = bcd;
        bad_busy = 1'b0;
        bad_hold = 1'b0;
        bin      = v;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 20) begin
            if (busy !== 1'b1) bad_busy = 1'b1;
            if (bcd !== prev) bad_hold = 1'b1;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, 11);
        check({tag, " busy/hold"}, {bad_busy, bad_hold, busy}, 3'b000);
        check({tag, " bcd"}, bcd, exp);
    endtask

    initial begin
        logic [15:0] prev;
        int lat;
        int n_done;
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        start = 1'b0;
        bin   = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset bcd", bcd, 16'h0000);
        reset = 1'b0;
        @(negedge clk);

        // Basic directed values, each followed by a single-pulse check.
        run_conv(10'd0, 16'h0000, "bin=0");
        @(negedge clk);
        check("bin=0 single done", done, 0);
        run_conv(10'd999, 16'h0999, "bin=999");
        @(negedge clk);
        check("bin=999 single done", done, 0);
        run_conv(10'd1023, 16'h1023, "bin=1023");
        @(negedge clk);
        check("bin=1023 single done", done, 0);

        // Start while busy is dropped and bin is not resampled.
        bin   = 10'd345;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        bin   = 10'd678;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 4;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("overlap latency", lat, 11);
        check("overlap bcd", bcd, 16'h0345);
        n_done = 0;
        prev   = bcd;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) n_done++;
        end
        check("overlap dropped", n_done, 0);
        check("overlap bcd held", bcd, prev);

        // Reset mid-conversion discards everything.
        bin   = 10'd512;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset busy/done", {busy, done}, 2'b00);
        check("midreset bcd", bcd, 16'h0000);
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        check("midreset no done", n_done, 0);
        run_conv(10'd57, 16'h0057, "bin=57");
        @(negedge clk);

        // Back-to-back: second start in the done cycle of the first.
        run_conv(10'd12, 16'h0012, "b2b first");
        run_conv(10'd34, 16'h0034, "b2b second");
        @(negedge clk);

        // Full sweep, each conversion started in the previous done cycle.
        for (int i = 0; i < 1024; i++) begin
            run_conv(10'(i), ref_bcd(i), $sformatf("sweep %0d", i));
        end
        @(negedge clk);
        check("sweep end single done", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard bound in case the DUT stalls outside a bounded wait.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
